// File: rtl/if_stage.sv
// Instruction fetch stage: PC register, IF/ID pipeline register and a
// BOOT/RUN/HALT sequencer with jump/branch redirect and halt-opcode detection.
module if_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_i,
  input  logic        branch_i,
  input  logic [31:0] branch_target_i,
  input  logic        jump_i,
  input  logic [25:0] jump_index_i,
  output logic [31:0] imem_addr_o,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] ifid_instr_o,
  output logic [31:0] ifid_pc4_o,
  output logic        ifid_valid_o,
  output logic [5:0]  op_o,
  output logic        halted_o,
  output logic [15:0] fetch_cnt_o
);

  localparam logic [5:0] OP_HALT = 6'd63;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc4_q, pc4_d;
  logic        valid_q, valid_d;
  logic [15:0] cnt_q, cnt_d;

  logic [31:0] pc_plus4;
  logic [31:0] jump_pc;
  logic [31:0] branch_pc;

  assign pc_plus4  = pc_q + 32'd4;
  assign jump_pc   = {pc4_q[31:28], jump_index_i, 2'b00};
  assign branch_pc = branch_target_i & 32'hFFFF_FFFC;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    case (state_q)
      BOOT: state_d = RUN;
      RUN: begin
        // Redirects win over stall and over a fetched halt word.
        if (jump_i || branch_i) begin
          pc_d    = jump_i ? jump_pc : branch_pc;
          instr_d = 32'h0;
          pc4_d   = 32'h0;
          valid_d = 1'b0;
        end else if (!stall_i) begin
          if (imem_rdata_i[31:26] == OP_HALT) begin
            instr_d = 32'h0;
            pc4_d   = 32'h0;
            valid_d = 1'b0;
            state_d = HALT;
          end else begin
            instr_d = imem_rdata_i;
            pc4_d   = pc_plus4;
            valid_d = 1'b1;
            pc_d    = pc_plus4;
            cnt_d   = cnt_q + 16'd1;
          end
        end
      end
      HALT: state_d = HALT;
      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BOOT;
      pc_q    <= 32'h0;
      instr_q <= 32'h0;
      pc4_q   <= 32'h0;
      valid_q <= 1'b0;
      cnt_q   <= 16'h0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  assign imem_addr_o  = pc_q;
  assign ifid_instr_o = instr_q;
  assign ifid_pc4_o   = pc4_q;
  assign ifid_valid_o = valid_q;
  assign op_o         = instr_q[31:26];
  assign halted_o     = (state_q == HALT);
  assign fetch_cnt_o  = cnt_q;

endmodule
